// File: rtl/axi_ext_reg_slave.sv
// AXI4-Lite register responder for the Nios external master port: version, IRQ status/mask,
// scratch and a bank of general-purpose control registers. One outstanding transaction per
// channel; read and write channels run independently.
`timescale 1ns/1ps
module axi_ext_reg_slave #(
  parameter logic [27:0] BASE_ADDR = 28'h0000000,
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [27:0]              s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wlast,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [27:0]              s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic [1:0]               irq_event_in,
  output logic [1:0]               irq_out,
  output logic [32*NUM_REGS-1:0]   gp_reg_out
);

  localparam int unsigned NumIdx = 4 + NUM_REGS;
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Word index relative to BASE_ADDR; addr[1:0] dropped.
  function automatic logic [25:0] word_idx(input logic [27:0] addr);
    logic [27:0] off;
    off = addr - BASE_ADDR;
    return off[27:2];
  endfunction

  function automatic logic addr_ok(input logic [27:0] addr);
    return (addr >= BASE_ADDR) && (word_idx(addr) < 26'(NumIdx));
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [27:0] aw_addr_q, aw_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  irq_status_q, irq_status_d, irq_mask_q, irq_mask_d, irq_out_q;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] gp_q [NUM_REGS];
  logic [31:0] gp_d [NUM_REGS];

  logic        commit, wr_en;
  logic [25:0] wr_idx, rd_idx;
  logic [1:0]  clr;
  logic [31:0] rd_val;

  // Write channel: independent AW/W capture, commit once both are held, hold B until accepted.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = aw_held_q & w_held_q;
    wr_idx    = word_idx(aw_addr_q);
    wr_en     = commit & addr_ok(aw_addr_q);
    if (s_axi_awvalid && awready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr;
    end
    if (s_axi_wvalid && wready_q) begin
      w_held_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = addr_ok(aw_addr_q) ? RespOkay : RespSlvErr;
    end
    // Readies stay low from capture until the B handshake completes.
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Register file next state; a same-cycle event wins over a W1C clear.
  always_comb begin
    scratch_d  = scratch_q;
    irq_mask_d = irq_mask_q;
    gp_d       = gp_q;
    clr        = 2'b00;
    if (wr_en) begin
      unique case (wr_idx)
        26'd1: if (w_strb_q[0]) clr = w_data_q[1:0];
        26'd2: if (w_strb_q[0]) irq_mask_d = w_data_q[1:0];
        26'd3: scratch_d = apply_strb(scratch_q, w_data_q, w_strb_q);
        default: begin
          for (int n = 0; n < int'(NUM_REGS); n++) begin
            if (wr_idx == 26'(4 + n)) gp_d[n] = apply_strb(gp_q[n], w_data_q, w_strb_q);
          end
        end
      endcase
    end
    irq_status_d = (irq_status_q & ~clr) | irq_event_in;
  end

  // Read channel: data is captured from the pre-update register values on the AR handshake.
  always_comb begin
    rd_idx = word_idx(s_axi_araddr);
    rd_val = '0;
    if (addr_ok(s_axi_araddr)) begin
      unique case (rd_idx)
        26'd0: rd_val = VERSION;
        26'd1: rd_val = {30'd0, irq_status_q};
        26'd2: rd_val = {30'd0, irq_mask_q};
        26'd3: rd_val = scratch_q;
        default: begin
          for (int n = 0; n < int'(NUM_REGS); n++) begin
            if (rd_idx == 26'(4 + n)) rd_val = gp_q[n];
          end
        end
      endcase
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (s_axi_arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = addr_ok(s_axi_araddr) ? RespOkay : RespSlvErr;
    end
    arready_d = ~rvalid_d;
  end

  // State registers; readies come up on the first edge after reset releases.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      irq_status_q <= 2'b00;
      irq_mask_q   <= 2'b00;
      irq_out_q    <= 2'b00;
      scratch_q    <= '0;
      for (int n = 0; n < int'(NUM_REGS); n++) gp_q[n] <= '0;
    end else begin
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      aw_addr_q    <= aw_addr_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      irq_out_q    <= irq_status_q & irq_mask_q;
      scratch_q    <= scratch_d;
      gp_q         <= gp_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_gp_out
    assign gp_reg_out[32*g +: 32] = gp_q[g];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign irq_out       = irq_out_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wlast};

endmodule

// File: tb/tb_axi_ext_reg_slave.sv
// Directed bench for axi_ext_reg_slave with hand-computed expectations.
`timescale 1ns/1ps
module tb_axi_ext_reg_slave;

  localparam int unsigned NumRegs = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [27:0]             awaddr = '0;
  logic                    awvalid = 1'b0;
  logic                    awready;
  logic [31:0]             wdata = '0;
  logic [3:0]              wstrb = '0;
  logic                    wvalid = 1'b0;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready = 1'b0;
  logic [27:0]             araddr = '0;
  logic                    arvalid = 1'b0;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready = 1'b0;
  logic [1:0]              irq_ev = '0;
  logic [1:0]              irq_o;
  logic [32*NumRegs-1:0]   gp_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_ext_reg_slave #(
    .BASE_ADDR (28'h0000000),
    .NUM_REGS  (NumRegs),
    .VERSION   (32'h0001_0000)
  ) u_dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'b000),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (1'b1),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'b000),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .irq_event_in  (irq_ev),
    .irq_out       (irq_o),
    .gp_reg_out    (gp_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with bready high; samples handshakes on the falling edge.
  task automatic axi_write(input logic [27:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs, b_hs, done;
    done = 1'b0;
    resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      b_hs  = bvalid & bready;
      if (b_hs) resp = bresp;
      tick();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      if (b_hs) done = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check("wr_done", 32'(done), 32'd1);
  endtask

  task automatic axi_read(input logic [27:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic ar_hs, r_hs, done;
    done = 1'b0;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      ar_hs = arvalid & arready;
      r_hs  = rvalid & rready;
      if (r_hs) begin
        data = rdata;
        resp = rresp;
      end
      tick();
      if (ar_hs) arvalid = 1'b0;
      if (r_hs) done = 1'b1;
    end
    arvalid = 1'b0; rready = 1'b0;
    check("rd_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_aw", 32'(awready), 32'd1);
    check("ready_w", 32'(wready), 32'd1);
    check("ready_ar", 32'(arready), 32'd1);
    check("gp_rst_lo", gp_o[31:0], 32'd0);
    check("gp_rst_hi", gp_o[255:224], 32'd0);

    // Version read with latency checks
    araddr = 28'h00; arvalid = 1'b1;
    @(negedge clk);
    check("rvalid_pre", 32'(rvalid), 32'd0);
    tick();
    arvalid = 1'b0;
    check("rvalid_lat", 32'(rvalid), 32'd1);
    check("arready_busy", 32'(arready), 32'd0);
    check("ver_data", rdata, 32'h0001_0000);
    check("ver_resp", 32'(rresp), 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);

    // W leads AW by three cycles, partial strobes, bready held low
    wdata = 32'hA5A5_5A5A; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w_cap_wready", 32'(wready), 32'd0);
    check("w_cap_awready", 32'(awready), 32'd1);
    repeat (2) tick();
    awaddr = 28'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("aw_cap_bvalid", 32'(bvalid), 32'd0);
    tick();
    check("b_lat", 32'(bvalid), 32'd1);
    check("gp0_strb", gp_o[31:0], 32'h00A5_005A);
    check("gp0_bresp", 32'(bresp), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_hold", 32'(bvalid), 32'd1);
      check("b_hold_rdy", 32'({awready, wready}), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", 32'(bvalid), 32'd0);
    check("b_done_rdy", 32'({awready, wready}), 32'd3);

    // IRQ mask, event, event-vs-W1C priority, clear
    axi_write(28'h08, 32'h3, 4'hF, r);
    check("mask_resp", 32'(r), 32'd0);
    irq_ev = 2'b10;
    tick();
    irq_ev = 2'b00;
    check("irq_1edge", 32'(irq_o), 32'd0);
    tick();
    check("irq_2edge", 32'(irq_o), 32'd2);
    awaddr = 28'h04; wdata = 32'h2; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    irq_ev = 2'b10;
    tick();
    irq_ev = 2'b00;
    check("w1c_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(28'h04, d, r);
    check("w1c_vs_event", d, 32'h2);
    check("irq_still", 32'(irq_o), 32'd2);
    axi_write(28'h04, 32'h2, 4'hF, r);
    check("irq_clear", 32'(irq_o), 32'd0);
    axi_read(28'h04, d, r);
    check("status_clr", d, 32'h0);
    axi_read(28'h08, d, r);
    check("mask_rd", d, 32'h3);

    // Decode boundaries
    axi_read(28'h30, d, r);
    check("oor_rresp", 32'(r), 32'd2);
    check("oor_rdata", d, 32'd0);
    axi_write(28'h30, 32'hFFFF_FFFF, 4'hF, r);
    check("oor_bresp", 32'(r), 32'd2);
    check("oor_gp0", gp_o[31:0], 32'h00A5_005A);
    check("oor_gp7", gp_o[255:224], 32'd0);
    axi_write(28'h2C, 32'hDEAD_BEEF, 4'hF, r);
    check("gp7_bresp", 32'(r), 32'd0);
    check("gp7_out", gp_o[255:224], 32'hDEAD_BEEF);
    axi_read(28'h2E, d, r);
    check("gp7_rd", d, 32'hDEAD_BEEF);
    check("gp7_rresp", 32'(r), 32'd0);

    // Simultaneous read and write of SCRATCH
    axi_write(28'h0C, 32'hCAFE_F00D, 4'hF, r);
    araddr = 28'h0C; arvalid = 1'b1;
    awaddr = 28'h0C; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("sim_rvalid", 32'(rvalid), 32'd1);
    check("sim_old", rdata, 32'hCAFE_F00D);
    tick();
    check("sim_bvalid", 32'(bvalid), 32'd1);
    check("sim_hold", rdata, 32'hCAFE_F00D);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("sim_both_done", 32'({rvalid, bvalid}), 32'd0);
    axi_read(28'h0C, d, r);
    check("sim_new", d, 32'h1234_5678);

    // Reset with AW held and W never sent
    awaddr = 28'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_aw", 32'(awready), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_b", 32'(bvalid), 32'd0);
    end
    axi_read(28'h0C, d, r);
    check("mid_scratch", d, 32'd0);
    check("mid_gp0", gp_o[31:0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ext_reg_slave.md
# axi_ext_reg_slave

AXI4-Lite responder that terminates the Nios external AXI master port (28-bit address, 32-bit data) in FPGA fabric. It provides a version register, a 2-bit interrupt status/mask pair driving the Nios receiver IRQ inputs, and a bank of general-purpose read/write control registers. The CPU reads and writes these registers over the AXI port; fabric logic consumes the control outputs and raises interrupt events.

## Interface
- BASE_ADDR, 28'h0000000, byte address of register 0 within the AXI window
- NUM_REGS, 8, number of GP registers (1..32)
- VERSION, 32'h0001_0000, value returned by the version register
- clk_clk  in  1  system clock, all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  28  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wlast  in  1  ignored (single beat only)
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
- s_axi_araddr  in  28  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, same encoding as bresp
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
- irq_event_in  in  2  per-bit event pulses; a bit high in a cycle sets that status bit
- irq_out  out  2  registered (IRQ_STATUS & IRQ_MASK), connected to the Nios receiver IRQ inputs
- gp_reg_out  out  32*NUM_REGS  GP register contents; register n occupies bits [32n+31:32n]

## Operation
- Offset = addr − BASE_ADDR. addr[1:0] is ignored (word access).
- Register map:
  - 0x00 VERSION: read-only; writes are accepted with OKAY and have no effect.
  - 0x04 IRQ_STATUS: bits [1:0]; writing 1 clears a bit (W1C); bits [31:2] read 0.
  - 0x08 IRQ_MASK: bits [1:0] read/write.
  - 0x0C SCRATCH: 32-bit read/write.
  - 0x10 + 4n: GP register n, for n < NUM_REGS.
- Any offset outside 0x00..0x0C+4*NUM_REGS, or addr below BASE_ADDR, returns SLVERR. Writes to such offsets are dropped; reads return 0x0000_0000.
- wstrb[i] enables byte i on RW registers. For W1C, a cleared byte lane leaves its bits untouched.
- Write path: AW and W are captured independently, in either order or in the same cycle.
  - awready deasserts once AW is held and stays low until the B handshake; wready behaves the same for W.
  - Once both are held, the register update and bvalid=1 occur on the next edge.
  - bvalid/bresp stay stable until bready is sampled high.
- Read path: arready is high while no read is pending. After the AR handshake, rvalid/rdata/rresp are registered on the next edge and held until rready is sampled high. arready is low from the handshake until that point.
- Read and write channels are independent and may complete in the same cycle.
- IRQ_STATUS bit update priority: an event set in the same cycle as a W1C clear on the same bit leaves the bit at 1.
- A read of IRQ_STATUS returns the value before any same-cycle update.
- Reset (asynchronous):
  - All ready/valid outputs go to 0; bresp, rresp and rdata go to 0.
  - IRQ_STATUS, IRQ_MASK, SCRATCH, all GP registers and irq_out go to 0.
  - Any in-flight transaction is discarded.
  - awready, wready and arready rise on the first edge after reset deasserts.

## Timing
- Write latency: edge of the last of AW/W captured → bvalid high one edge later. Minimum 2 cycles from valid to bvalid with immediate ready.
- Read latency: AR handshake edge → rvalid high on the next edge.
- Throughput with bready/rready held high: one write per 3 cycles and one read per 2 cycles. No pipelining of outstanding transactions; one outstanding per channel.
- gp_reg_out reflects a write on the same edge bvalid rises.
- irq_out timing:
  - Rises one edge after a status or mask change becomes visible (2 edges after irq_event_in for a masked-on bit).
  - Falls one edge after the W1C write commits.

## Test plan
- Reset, then read 0x00 → rdata=0x0001_0000, rresp=OKAY, rvalid one edge after AR handshake; gp_reg_out=0 and all readies high after the first edge.
- W driven 3 cycles before AW to 0x10 with data 0xA5A5_5A5A and wstrb=4'b0101 → GP0=0x00A5_005A, bresp=OKAY. With bready held low for 4 cycles, bvalid holds and awready/wready stay low.
- Write 0x3 to 0x08, pulse irq_event_in=2'b10 → irq_out=2'b10 two edges later. In one cycle, write 0x2 to 0x04 while also pulsing irq_event_in[1] → IRQ_STATUS bit 1 stays 1. Write 0x2 alone → irq_out=0.
- NUM_REGS=8, read 0x30 and write 0x30 → rresp=SLVERR with rdata=0; bresp=SLVERR with no register change. Offset 0x2C (GP7) → OKAY.
- Simultaneous read of 0x0C and write of 0x0C with 0x1234_5678 → read returns the old SCRATCH value and both responses complete. Assert reset mid-write (AW held, W not yet sent) → bvalid never rises and SCRATCH=0.
